// File: rtl/mem_arbiter_pkg.sv
// MemArbPkg: shared requester indices, widths and memory command struct for mem_arbiter
package MemArbPkg;
  localparam int NUM_REQ = 3;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  typedef enum logic [1:0] {
    REQ_DVI    = 2'd0,
    REQ_IFETCH = 2'd1,
    REQ_DATA   = 2'd2
  } req_idx_e;
  typedef struct packed {
    logic                    en;
    logic [MEM_DATA_W/8-1:0] we;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W-1:0]   wdata;
  } mem_cmd_st;
endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: two-way round-robin pick (req[0]=ifetch, req[1]=data; pick=1 selects data) with pointer register advanced by adv
module mem_arb_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic       pick
);
  logic ptr;
  assign pick = req[1] && (!req[0] || !ptr);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= 1'b1;
    else if (adv) ptr <= pick;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: 3-way single-port memory arbiter (DVI read priority with starvation cap, ifetch/data round-robin); ports: i_req/i_we/i_addr/i_wdata/i_wstrb in, o_gnt/o_rvalid/o_rdata out, o_mem_* command, i_mem_rdata
module mem_arbiter
  import MemArbPkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DVI_RUN = 4
) (
  input  logic                               i_clk_core,
  input  logic                               i_rst_core,
  input  logic [NUM_REQ-1:0]                 i_req,
  input  logic [NUM_REQ-1:0]                 i_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]     i_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     i_wdata,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0]   i_wstrb,
  output logic [NUM_REQ-1:0]                 o_gnt,
  output logic [NUM_REQ-1:0]                 o_rvalid,
  output logic [DATA_W-1:0]                  o_rdata,
  output logic                               o_mem_en,
  output logic [DATA_W/8-1:0]                o_mem_we,
  output logic [ADDR_W-1:0]                  o_mem_addr,
  output logic [DATA_W-1:0]                  o_mem_wdata,
  input  logic [DATA_W-1:0]                  i_mem_rdata
);
  localparam int RUN_W = $clog2(MAX_DVI_RUN + 1);
  logic             core_req;
  logic             dvi_cap;
  logic             pick_data;
  logic             is_wr;
  logic [RUN_W-1:0] dvi_run;
  logic [NUM_REQ-1:0] rd_tag;
  req_idx_e         sel;
  mem_cmd_st        cmd;
  assign core_req = i_req[REQ_IFETCH] | i_req[REQ_DATA];
  assign dvi_cap  = core_req && dvi_run == RUN_W'(MAX_DVI_RUN);
  mem_arb_rr2 u_rr2 (
    .clk  (i_clk_core),
    .rst  (i_rst_core),
    .req  ({i_req[REQ_DATA], i_req[REQ_IFETCH]}),
    .adv  (o_gnt[REQ_IFETCH] | o_gnt[REQ_DATA]),
    .pick (pick_data)
  );
  assign o_gnt = i_rst_core ? '0 :
                 (i_req[REQ_DVI] && !dvi_cap) ? 3'b001 :
                 !core_req ? '0 :
                 pick_data ? 3'b100 : 3'b010;
  assign sel   = o_gnt[REQ_DATA] ? REQ_DATA : o_gnt[REQ_IFETCH] ? REQ_IFETCH : REQ_DVI;
  assign is_wr = sel != REQ_DVI && i_we[sel];
  always_comb begin
    cmd       = '0;
    cmd.en    = |o_gnt;
    cmd.we    = (cmd.en && is_wr) ? MEM_DATA_W'(i_wstrb[sel]) / 1 : '0;
    cmd.addr  = MEM_ADDR_W'(i_addr[sel]);
    cmd.wdata = MEM_DATA_W'(i_wdata[sel]);
  end
  assign o_mem_en    = cmd.en;
  assign o_mem_we    = (DATA_W/8)'(cmd.we);
  assign o_mem_addr  = ADDR_W'(cmd.addr);
  assign o_mem_wdata = DATA_W'(cmd.wdata);
  // A DVI grant can only happen below the cap while a core request waits, so
  // the increment never needs an explicit saturation check.
  always_ff @(posedge i_clk_core or posedge i_rst_core) begin
    if (i_rst_core) begin
      dvi_run <= '0;
      rd_tag  <= '0;
    end else begin
      dvi_run <= (core_req && o_gnt[REQ_DVI]) ? dvi_run + RUN_W'(1) : '0;
      rd_tag  <= (cmd.en && !is_wr) ? o_gnt : '0;
    end
  end
  assign o_rvalid = rd_tag;
  assign o_rdata  = i_mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed self-checking bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;
  localparam int MAX = 4;
  localparam logic [31:0] INIT [16] = '{
    32'hDEADBEEF, 32'h11110001, 32'h22220002, 32'h33330003,
    32'h44440004, 32'h55550005, 32'h66660006, 32'h77770007,
    32'h88880008, 32'h99990009, 32'hAAAA000A, 32'hBBBB000B,
    32'hCCCC000C, 32'hDDDD000D, 32'hEEEE000E, 32'hFFFF000F};
  logic clk, rst;
  logic [2:0] i_req, i_we;
  logic [2:0][31:0] i_addr, i_wdata;
  logic [2:0][3:0] i_wstrb;
  logic [2:0] o_gnt, o_rvalid;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic o_mem_en;
  logic [3:0] o_mem_we;
  logic [31:0] mem [16] = INIT;
  logic [31:0] mmem [16] = INIT;
  int nchk = 0, nerr = 0;
  int m_run = 0, m_pref = 1;
  logic [2:0] m_rv = '0;
  logic [31:0] m_rd = '0;
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DVI_RUN(MAX)) dut (
    .i_clk_core(clk), .i_rst_core(rst), .i_req(i_req), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .o_gnt(o_gnt),
    .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_mem_en(o_mem_en),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we == 4'b0) i_mem_rdata <= mem[o_mem_addr[3:0]];
      else for (int b = 0; b < 4; b++)
        if (o_mem_we[b]) mem[o_mem_addr[3:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
  end
  always @(negedge clk) begin : cmp
    logic core, wr;
    logic [2:0] eg;
    int cw, sel;
    if (rst) begin
      chk("rst_gnt", 64'(o_gnt), 0);
      chk("rst_mem_en", 64'(o_mem_en), 0);
      chk("rst_rvalid", 64'(o_rvalid), 0);
      m_run = 0;
      m_pref = 1;
      m_rv = '0;
    end else begin
      core = i_req[1] | i_req[2];
      cw = (i_req[1] && i_req[2]) ? m_pref : (i_req[1] ? 1 : 2);
      eg = (i_req[0] && !(m_run == MAX && core)) ? 3'b001 : core ? 3'(1 << cw) : 3'b000;
      sel = eg[0] ? 0 : eg[1] ? 1 : 2;
      wr = eg != 0 && sel != 0 && i_we[sel];
      chk("gnt", 64'(o_gnt), 64'(eg));
      chk("mem_en", 64'(o_mem_en), 64'(eg != 0));
      chk("mem_we", 64'(o_mem_we), wr ? 64'(i_wstrb[sel]) : 0);
      if (eg != 0) begin
        chk("mem_addr", 64'(o_mem_addr), 64'(i_addr[sel]));
        chk("mem_wdata", 64'(o_mem_wdata), 64'(i_wdata[sel]));
      end
      chk("rvalid", 64'(o_rvalid), 64'(m_rv));
      if (m_rv != 0) chk("rdata", 64'(o_rdata), 64'(m_rd));
      m_rv = (eg != 0 && !wr) ? eg : 3'b000;
      m_rd = mmem[i_addr[sel][3:0]];
      if (wr) for (int b = 0; b < 4; b++)
        if (i_wstrb[sel][b]) mmem[i_addr[sel][3:0]][8*b +: 8] = i_wdata[sel][8*b +: 8];
      m_run = !core ? 0 : eg[0] ? (m_run + 1 > MAX ? MAX : m_run + 1) : 0;
      if (eg[1] | eg[2]) m_pref = eg[1] ? 2 : 1;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic new_req(input int i);
    i_req[i] = $urandom_range(0, 2) != 0;
    i_we[i] = 1'($urandom_range(0, 1));
    i_addr[i] = $urandom;
    i_wdata[i] = $urandom;
    i_wstrb[i] = 4'($urandom_range(1, 15));
  endtask
  initial begin
    logic [2:0] e32 [4] = '{3'b010, 3'b100, 3'b010, 3'b100};
    logic [2:0] g;
    rst = 1;
    i_req = 3'b111;
    i_we = '0;
    i_addr = '0;
    i_wdata = '0;
    i_wstrb = '0;
    #2;
    chk("reset_gnt", 64'(o_gnt), 0);
    chk("reset_mem_en", 64'(o_mem_en), 0);
    chk("reset_rvalid", 64'(o_rvalid), 0);
    tick();
    tick();
    rst = 0;
    i_req = '0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("idle_en", 64'(o_mem_en), 0);
      chk("idle_gnt", 64'(o_gnt), 0);
      tick();
    end
    i_req = 3'b010;
    i_addr[1] = 32'h10;
    #1;
    chk("fetch_gnt", 64'(o_gnt), 64'(3'b010));
    tick();
    i_req = '0;
    #1;
    chk("fetch_rvalid", 64'(o_rvalid), 64'(3'b010));
    chk("fetch_rdata", 64'(o_rdata), 64'h0DEADBEEF);
    tick();
    i_req = 3'b010;
    i_addr[1] = 32'h3;
    tick();
    i_req = '0;
    #1;
    chk("pre_rst_rvalid", 64'(o_rvalid), 64'(3'b010));
    #1;
    rst = 1;
    #1;
    chk("rst_drop_rvalid", 64'(o_rvalid), 0);
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_rvalid", 64'(o_rvalid), 0);
      tick();
    end
    i_req = 3'b110;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_gnt", 64'(o_gnt), 64'(e32[k]));
      tick();
    end
    i_req = '0;
    tick();
    i_req = 3'b101;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk("starve_gnt", 64'(o_gnt), (k % 5 < 4) ? 64'(3'b001) : 64'(3'b100));
      tick();
    end
    i_req = 3'b100;
    i_we[2] = 1'b1;
    i_wstrb[2] = 4'b0011;
    i_wdata[2] = 32'hCAFEF00D;
    i_addr[2] = 32'h5;
    #1;
    chk("wr_gnt", 64'(o_gnt), 64'(3'b100));
    chk("wr_mem_we", 64'(o_mem_we), 64'(4'b0011));
    tick();
    i_req = '0;
    i_we = '0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("wr_no_rvalid", 64'(o_rvalid), 0);
      tick();
    end
    for (int i = 0; i < 3; i++) new_req(i);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      g = o_gnt;
      tick();
      if (rst) rst = 0;
      for (int i = 0; i < 3; i++) if (!i_req[i] || g[i]) new_req(i);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1;
      end
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: word-address width of the shared memory port.
REQ-002 Parameter DATA_W, default 32: data width; byte strobes are DATA_W/8 bits wide.
REQ-003 Parameter MAX_DVI_RUN, default 4: maximum consecutive DVI grants allowed while a core requester waits.
REQ-004 i_clk_core  in  1  the single clock; all state changes on its rising edge.
REQ-005 i_rst_core  in  1  asynchronous, active-high reset.
REQ-006 i_req  in  3  request per requester: bit 0 = DVI read, bit 1 = instruction fetch, bit 2 = data.
REQ-007 i_we  in  3  write enable per requester; i_we[0] is ignored because DVI only reads.
REQ-008 i_addr  in  3 x ADDR_W  address per requester.
REQ-009 i_wdata / i_wstrb  in  3 x DATA_W / 3 x DATA_W/8  write data and byte strobes per requester.
REQ-010 o_gnt  out  3  one-hot-or-zero grant; a request is accepted in the cycle its o_gnt bit is high.
REQ-011 o_rvalid  out  3  one-hot-or-zero read-data-valid, tagged by requester.
REQ-012 o_rdata  out  DATA_W  read data shared by all requesters, qualified by o_rvalid.
REQ-013 o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata  out  1, DATA_W/8, ADDR_W, DATA_W  single-port memory command.
REQ-014 i_mem_rdata  in  DATA_W  memory read data, one cycle after o_mem_en with o_mem_we == 0.

Function
REQ-015 o_gnt, and o_mem_* from the granted requester, are combinational from i_req and registered state; there are zero cycles from request to grant.
REQ-016 A requester holds i_req, i_we, i_addr, i_wdata and i_wstrb stable until it sees o_gnt; the arbiter does not buffer requests.
REQ-017 When no request is present, o_gnt = 0, o_mem_en = 0 and o_mem_we = 0.
REQ-018 Priority: DVI wins, except when dvi_run == MAX_DVI_RUN and i_req[1] or i_req[2] is high; in that case the core requester selected by REQ-019 wins.
REQ-019 Between requesters 1 and 2, a 1-bit round-robin pointer selects the winner when both request; after a core grant, the pointer points at the other core requester; a lone core request wins regardless of the pointer.
REQ-020 dvi_run counter rules:
  - increments, saturating at MAX_DVI_RUN, on a DVI grant while any core request is pending;
  - clears to 0 on any core grant;
  - clears to 0 in any cycle with no core request.
REQ-021 Write grant: o_mem_we = the granted requester's i_wstrb; o_rvalid does not assert for writes.
REQ-022 Read grant: the matching o_rvalid bit asserts exactly one cycle later; o_rdata = i_mem_rdata passes through combinationally.
REQ-023 Back-to-back reads from different requesters in consecutive cycles produce consecutive, correctly tagged o_rvalid pulses.
REQ-024 A requester may issue a new request in the same cycle as its previous o_rvalid.

Reset
REQ-025 Asserting i_rst_core takes effect immediately, independent of the clock.
REQ-026 Reset values: o_rvalid = 0, dvi_run = 0, round-robin pointer = 1 (instruction fetch preferred).
REQ-027 An outstanding read is discarded on reset; no o_rvalid is issued for it after reset releases.
REQ-028 While i_rst_core is high, o_gnt = 0 and o_mem_en = 0.

Structure
REQ-029 Package MemArbPkg holds:
  - NUM_REQ = 3;
  - requester index enum REQ_DVI = 0, REQ_IFETCH = 1, REQ_DATA = 2;
  - mem_cmd_st, a struct of en, we, addr, wdata.
REQ-030 The two-way round-robin pick and pointer register are the single sub-module mem_arb_rr2; the priority and starvation logic stays in mem_arbiter.

Verification
REQ-031 Single fetch read at 0x10, memory word 0xDEADBEEF -> o_gnt = 3'b010 in the same cycle; o_rvalid = 3'b010 and o_rdata = 0xDEADBEEF on the next cycle.
REQ-032 req[1] and req[2] held high for 4 cycles after reset -> grants 010, 100, 010, 100.
REQ-033 req[0] and req[2] held continuously with MAX_DVI_RUN = 4 -> grant pattern: DVI x4, data x1, repeating.
REQ-034 Data write with wstrb 0b0011 while DVI idle -> o_mem_we = 0b0011 and no o_rvalid in any cycle.
REQ-035 Reset asserted mid-clock in the cycle after a read grant -> o_rvalid drops immediately and stays 0 after release; pointer = 1, dvi_run = 0.
REQ-036 No requests for 10 cycles -> o_mem_en = 0, o_gnt = 0 and dvi_run = 0 throughout.
